// File: rtl/camera_cfg_pkg.sv
// camera_cfg_pkg: shared FSM states, ROM markers and address width for the camera init sequencer
package camera_cfg_pkg;
  localparam int ROM_AW = 7;
  localparam logic [15:0] END_MARKER = 16'hFFFF;
  localparam logic [15:0] DELAY_MARKER = 16'hFFF0;
  typedef enum logic [3:0] {
    IDLE, FETCH, WAIT_ROM, DECODE, SEND, WAIT_ACK, DELAY, DONE, ERROR
  } state_e;
endpackage

// File: rtl/cfg_delay_timer.sv
// cfg_delay_timer: down-counter loaded with CYCLES; expired_o flags the final cycle of the wait
module cfg_delay_timer #(
  parameter int CYCLES = 5,
  parameter int W = $clog2(CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expired_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? W'(CYCLES) : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // A load of N gives exactly N cycles with a nonzero count, the last one reading 1
  assign expired_o = cnt_q == W'(1);
endmodule

// File: rtl/camera_config_seq.sv
// camera_config_seq: walks the init ROM, issuing SCCB writes with retries and timed delay entries
module camera_config_seq
  import camera_cfg_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int DELAY_MS = 10,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_val,
  input  logic              sccb_busy,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_error
);
  localparam int DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_e            state_q, state_d;
  logic [ROM_AW-1:0] addr_q, addr_d, next_addr;
  logic [7:0]        reg_q, reg_d, val_q, val_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [RW:0]       retry_inc;
  logic              done_q, done_d, error_q, error_d;
  logic              delay_load, delay_expired;
  state_e            after_entry;

  cfg_delay_timer #(.CYCLES(DELAY_CYCLES)) u_delay (
    .clk      (clk),
    .rst      (reset),
    .load_i   (delay_load),
    .expired_o(delay_expired)
  );

  // The last ROM slot finishes the sequence instead of wrapping back to 0
  assign next_addr   = &addr_q ? addr_q : addr_q + ROM_AW'(1);
  assign after_entry = &addr_q ? DONE : FETCH;
  assign retry_inc   = {1'b0, retry_q} + (RW + 1)'(1);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      reg_q   <= '0;
      val_q   <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      error_q <= error_d;
    end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    val_d   = val_q;
    retry_d = retry_q;
    done_d  = done_q;
    error_d = error_q;
    case (state_q)
      IDLE:
        if (cfg_start) begin
          state_d = FETCH;
          addr_d  = '0;
          retry_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      FETCH:    state_d = WAIT_ROM;
      WAIT_ROM: state_d = DECODE;
      DECODE:
        if (rom_data == END_MARKER) state_d = DONE;
        else if (rom_data == DELAY_MARKER) state_d = DELAY;
        else begin
          reg_d   = rom_data[15:8];
          val_d   = rom_data[7:0];
          state_d = SEND;
        end
      SEND:     state_d = sccb_busy ? SEND : WAIT_ACK;
      WAIT_ACK:
        if (sccb_done && !sccb_nack) begin
          retry_d = '0;
          addr_d  = next_addr;
          state_d = after_entry;
        end else if (sccb_done) begin
          retry_d = retry_inc[RW-1:0];
          state_d = retry_inc < (RW + 1)'(MAX_RETRY) ? SEND : ERROR;
        end
      DELAY:
        if (delay_expired) begin
          addr_d  = next_addr;
          state_d = after_entry;
        end
      default:  state_d = IDLE;
    endcase
    if (state_d == DONE) done_d = 1'b1;
    if (state_d == ERROR) error_d = 1'b1;
  end

  always_comb begin
    sccb_start = state_q == SEND && !sccb_busy;
    cfg_busy   = state_q != IDLE;
    delay_load = state_q == DECODE && rom_data == DELAY_MARKER;
  end

  assign rom_addr  = addr_q;
  assign sccb_reg  = reg_q;
  assign sccb_val  = val_q;
  assign cfg_done  = done_q;
  assign cfg_error = error_q;
endmodule

// File: tb/tb_camera_config_seq.sv
// tb_camera_config_seq: directed and random ROM sequences against a list-walking reference model
module tb_camera_config_seq;
  localparam int DLY = 5;
  localparam int MR = 3;

  typedef struct {
    logic [7:0] r;
    logic [7:0] v;
    int         gap;
  } wr_t;

  logic        clk = 1'b0, reset = 1'b1, cfg_start = 1'b0;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_start, sccb_busy;
  logic [7:0]  sccb_reg, sccb_val;
  logic        s_busy = 1'b0, ext_busy = 1'b0, sccb_done = 1'b0, sccb_nack = 1'b0;
  logic        cfg_busy, cfg_done, cfg_error;

  logic [15:0] rom [128];
  int          nacks [128];
  int          att [128];
  wr_t         obs[$], exp_q[$];
  int          cyc = 0, trig = 0, start_cyc = 0, viol_busy = 0, viol_stab = 0;
  logic [15:0] cur = '0;
  int          s_run = 0, run_id = 0, lat;
  logic        nk;
  int          checks = 0, errors = 0, base = 0;
  int          exp_done, exp_err, exp_addr;

  assign sccb_busy = s_busy | ext_busy;

  camera_config_seq #(.CLK_FREQ_HZ(1000), .DELAY_MS(DLY), .MAX_RETRY(MR)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_start (cfg_start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .sccb_start(sccb_start),
    .sccb_reg  (sccb_reg),
    .sccb_val  (sccb_val),
    .sccb_busy (sccb_busy),
    .sccb_done (sccb_done),
    .sccb_nack (sccb_nack),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Gap = cycles from the last trigger (cfg_start or any sccb_done) to each write request
  always @(negedge clk) begin
    if (sccb_start) begin
      obs.push_back('{sccb_reg, sccb_val, cyc - (trig > start_cyc ? trig : start_cyc)});
      cur <= {sccb_reg, sccb_val};
      if (sccb_busy) viol_busy <= viol_busy + 1;
    end
    if (sccb_done) begin
      trig <= cyc;
      if ({sccb_reg, sccb_val} != cur) viol_stab <= viol_stab + 1;
    end
  end

  // SCCB slave: NACKs the first nacks[addr] attempts of an entry within one run
  always begin
    @(negedge clk);
    if (sccb_start) begin
      if (s_run != run_id) begin
        for (int i = 0; i < 128; i++) att[i] = 0;
        s_run = run_id;
      end
      nk = att[rom_addr] < nacks[rom_addr];
      att[rom_addr] = att[rom_addr] + 1;
      lat = int'($urandom_range(4, 1));
      @(posedge clk);
      #1 s_busy = 1'b1;
      repeat (lat) @(posedge clk);
      #1;
      s_busy = 1'b0;
      sccb_done = 1'b1;
      sccb_nack = nk;
      @(posedge clk);
      #1;
      sccb_done = 1'b0;
      sccb_nack = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, 32'(rom_addr), 0);
    check({tag, "_start"}, 32'(sccb_start), 0);
    check({tag, "_reg"}, 32'(sccb_reg), 0);
    check({tag, "_val"}, 32'(sccb_val), 0);
    check({tag, "_busy"}, 32'(cfg_busy), 0);
    check({tag, "_done"}, 32'(cfg_done), 0);
    check({tag, "_error"}, 32'(cfg_error), 0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) begin
      rom[i] = 16'hFFFF;
      nacks[i] = 0;
    end
  endtask

  // Each fetched entry costs 3 cycles before SEND; each delay entry adds 3 + DLY
  task automatic model(input int hold);
    int d = 0;
    exp_q.delete();
    exp_done = 0;
    exp_err = 0;
    exp_addr = 0;
    for (int a = 0; a < 128; a++) begin
      exp_addr = a;
      if (rom[a] == 16'hFFFF) begin
        exp_done = 1;
        break;
      end
      if (rom[a] == 16'hFFF0) d++;
      else begin
        for (int t = 0; t < MR && t <= nacks[a]; t++)
          exp_q.push_back('{rom[a][15:8], rom[a][7:0], t == 0 ? 4 + (3 + DLY) * d : 1});
        d = 0;
        if (nacks[a] >= MR) begin
          exp_err = 1;
          break;
        end
      end
      if (a == 127) exp_done = 1;
    end
    if (hold > 0 && exp_q.size() > 0 && exp_q[0].gap < hold) exp_q[0].gap = hold;
  endtask

  task automatic start_run(input int hold);
    model(hold);
    run_id++;
    base = obs.size();
    @(posedge clk);
    #1;
    cfg_start = 1'b1;
    start_cyc = cyc;
    ext_busy = hold > 0;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    if (hold > 0) begin
      repeat (hold - 1) @(posedge clk);
      #1 ext_busy = 1'b0;
    end
  endtask

  task automatic finish_run(input string tag);
    int n = 0;
    while (cfg_busy === 1'b1 && n < 20000) begin
      @(posedge clk);
      #1 n++;
    end
    @(negedge clk);
    check({tag, "_timeout"}, 32'(n < 20000), 1);
    check({tag, "_done"}, 32'(cfg_done), 32'(exp_done));
    check({tag, "_error"}, 32'(cfg_error), 32'(exp_err));
    check({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    check({tag, "_busy"}, 32'(cfg_busy), 0);
    check({tag, "_nwrites"}, 32'(obs.size() - base), 32'(exp_q.size()));
    check({tag, "_start_vs_busy"}, 32'(viol_busy), 0);
    check({tag, "_regval_stable"}, 32'(viol_stab), 0);
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < obs.size()) begin
        check($sformatf("%s_w%0d_reg", tag, i), 32'(obs[base + i].r), 32'(exp_q[i].r));
        check($sformatf("%s_w%0d_val", tag, i), 32'(obs[base + i].v), 32'(exp_q[i].v));
        check($sformatf("%s_w%0d_gap", tag, i), 32'(obs[base + i].gap), 32'(exp_q[i].gap));
      end
  endtask

  initial begin
    int n, s0, len;
    clear_rom();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) reset = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("reset_no_req", 32'(obs.size()), 0);

    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1214; rom[3] = 16'hFFFF;
    start_run(0);
    finish_run("normal");

    clear_rom();
    rom[0] = 16'h1180; rom[1] = 16'h2233; nacks[0] = 2;
    start_run(0);
    finish_run("nack_recover");

    clear_rom();
    rom[0] = 16'h1111; rom[1] = 16'h0C04; rom[2] = 16'h2222; nacks[1] = MR;
    start_run(0);
    finish_run("nack_exhaust");

    clear_rom();
    rom[0] = 16'h3344; rom[1] = 16'h5566;
    start_run(13);
    finish_run("backpressure");

    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1214;
    start_run(0);
    n = 0;
    while (sccb_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("middelay_ack_seen", 32'(n < 200), 1);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_zero("middelay_rst");
    s0 = obs.size();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("middelay_no_req", 32'(obs.size() - s0), 0);
    start_run(0);
    finish_run("middelay_restart");

    for (int r = 0; r < 3; r++) begin
      clear_rom();
      len = int'($urandom_range(10, 2));
      for (int i = 0; i < len; i++) begin
        rom[i] = ($urandom % 4 == 0) ? 16'hFFF0 : {8'($urandom_range(254, 0)), 8'($urandom)};
        nacks[i] = ($urandom % 8 == 0) ? MR : int'($urandom_range(2, 0));
      end
      start_run(0);
      finish_run($sformatf("rand%0d", r));
    end

    for (int i = 0; i < 128; i++) begin
      rom[i] = {8'($urandom_range(254, 0)), 8'($urandom)};
      nacks[i] = ($urandom % 4 == 0) ? 1 : 0;
    end
    start_run(0);
    repeat (60) @(posedge clk);
    #1 cfg_start = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    finish_run("full_rom");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/camera_config_seq.md
CAMERA_CONFIG_SEQ -- requirements
Module: camera_config_seq

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 100_000_000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter DELAY_MS, default 10, meaning the wait time in ms for each delay-marker entry.
REQ-003 The block SHALL have parameter MAX_RETRY, default 3, meaning the number of write attempts per entry before declaring an error.
REQ-004 The block SHALL have the following ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse that begins the configuration sequence.
- rom_addr  out  7  init ROM address.
- rom_data  in  16  ROM word {reg[15:8], value[7:0]}, registered by the ROM (1-cycle latency).
- sccb_start  out  1  one-cycle write request to the SCCB master.
- sccb_reg  out  8  register address for the write.
- sccb_val  out  8  register value for the write.
- sccb_busy  in  1  SCCB master transaction in progress.
- sccb_done  in  1  one-cycle pulse when the transaction ends.
- sccb_nack  in  1  qualified by sccb_done; high means the slave did not acknowledge.
- cfg_busy  out  1  sequence in progress.
- cfg_done  out  1  sticky; set on successful completion.
- cfg_error  out  1  sticky; set when retries are exhausted.

Function
REQ-005 The FSM SHALL have the states IDLE, FETCH, WAIT_ROM, DECODE, SEND, WAIT_ACK, DELAY, DONE and ERROR.
REQ-006 In IDLE, a cfg_start pulse SHALL clear cfg_done, cfg_error and the retry count, set rom_addr to 0, and go to FETCH.
REQ-007 FETCH SHALL hold rom_addr for one cycle; WAIT_ROM SHALL wait one cycle; DECODE SHALL sample rom_data.
- This gives 2 cycles from an address change to valid data.
REQ-008 In DECODE, 16'hFFFF SHALL go to DONE.
REQ-009 In DECODE, 16'hFFF0 SHALL load the delay counter and go to DELAY.
REQ-010 In DECODE, any other word SHALL latch sccb_reg = rom_data[15:8] and sccb_val = rom_data[7:0], then go to SEND.
REQ-011 SEND SHALL wait for sccb_busy = 0, then assert sccb_start for exactly one cycle and go to WAIT_ACK.
- sccb_reg and sccb_val SHALL stay stable from SEND until WAIT_ACK exits.
REQ-012 In WAIT_ACK, sccb_done with sccb_nack = 0 SHALL clear the retry count, increment rom_addr and go to FETCH.
REQ-013 In WAIT_ACK, sccb_done with sccb_nack = 1 SHALL increment the retry count.
- If the count is below MAX_RETRY, the FSM SHALL go to SEND and resend the same entry.
- Otherwise it SHALL set cfg_error and go to ERROR.
REQ-014 DELAY SHALL last exactly CLK_FREQ_HZ/1000*DELAY_MS cycles, then increment rom_addr and go to FETCH.
- The counter width SHALL be $clog2 of that count plus 1.
REQ-015 If an entry completes (write acknowledged or delay finished) at rom_addr = 127, the FSM SHALL go to DONE with no wrap to 0.
REQ-016 DONE SHALL set cfg_done; ERROR SHALL leave cfg_error set. Both SHALL return to IDLE on the next cycle.
REQ-017 cfg_busy SHALL be 1 in every state except IDLE.
REQ-018 cfg_start SHALL be ignored while cfg_busy = 1.
REQ-019 sccb_done outside WAIT_ACK SHALL be ignored.

Reset
REQ-020 Reset SHALL asynchronously force the following values, including mid-transaction and mid-delay:
- state = IDLE, rom_addr = 0.
- sccb_start, sccb_reg, sccb_val = 0.
- cfg_busy, cfg_done, cfg_error = 0.
- retry count and delay counter = 0.
REQ-021 After reset is released, the block SHALL issue no SCCB request until a new cfg_start.

Structure
REQ-022 The package camera_cfg_pkg SHALL hold the state enum, END_MARKER = 16'hFFFF, DELAY_MARKER = 16'hFFF0 and ROM_AW = 7.
REQ-023 The delay counter SHALL be a separate sub-module cfg_delay_timer with load/expired handshake; everything else SHALL be in camera_config_seq.

Verification
Bench parameters: CLK_FREQ_HZ=1000, DELAY_MS=5 (5-cycle delay), MAX_RETRY=3; ROM model with 1-cycle latency.
REQ-024 Normal run. ROM = {1280, FFF0, 1214, FFFF}; all writes acked.
- Required: sccb writes (12,80) then (12,14).
- Exactly 5 DELAY cycles between them.
- cfg_done = 1, cfg_busy = 0, 2 sccb_start pulses total.
REQ-025 NACK with recovery. Entry 11_80 is NACKed twice, then acked.
- Required: 3 sccb_start pulses with identical reg/val, then rom_addr advances; cfg_error = 0.
REQ-026 NACK exhaustion. Entry 0C_04 is NACKed on every attempt.
- Required: 3 attempts, cfg_error = 1, cfg_done = 0, return to IDLE, rom_addr frozen at that entry.
REQ-027 Busy back-pressure. sccb_busy is held high 10 cycles after DECODE.
- Required: sccb_start is asserted only in the first cycle with busy = 0; reg/val stay stable.
REQ-028 Reset mid-delay. reset is asserted at delay cycle 3.
- Required: all outputs are 0 immediately.
- A new cfg_start restarts from rom_addr = 0.
REQ-029 ROM without END_MARKER. All 128 entries are non-marker writes.
- Required: 128 writes, then DONE with no wrap.
- A cfg_start pulse during busy produces no restart.
